// File: rtl/spm_arbiter.sv
// Shares one single-port scratch-pad memory between the test loader, CPU data and CPU fetch ports.
// A LOAD/RUN/DRAIN mode FSM gates CPU access; RUN uses fixed priority with fetch anti-starvation.
module spm_arbiter #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              tst_as_,
  input  logic              tst_rw,
  input  logic [ADDR_W-1:0] tst_addr,
  input  logic [DATA_W-1:0] tst_wr_data,
  output logic              tst_rdy,
  output logic              tst_rd_vld,
  input  logic              mem_as_,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rdy,
  output logic              mem_rd_vld,
  input  logic              if_as_,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rdy,
  output logic              if_rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [ADDR_W-1:0] spm_addr,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic [1:0]        mode
);

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StLoad = 2'd0, StRun = 2'd1, StDrain = 2'd2} state_e;
  typedef enum logic [1:0] {OwnNone, OwnTst, OwnMem, OwnIf} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            gnt_tst, gnt_mem, gnt_if;
  logic            starved;

  assign starved = (starve_q == CW'(STARVE_MAX));

  // Grants are combinational and forced off while reset is held.
  always_comb begin
    gnt_tst = 1'b0;
    gnt_mem = 1'b0;
    gnt_if  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StLoad: gnt_tst = !tst_as_;
        StRun: begin
          if (!tst_as_)                       gnt_tst = 1'b1;
          else if (!mem_as_ && !if_as_ && starved) gnt_if = 1'b1;
          else if (!mem_as_)                  gnt_mem = 1'b1;
          else if (!if_as_)                   gnt_if  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    spm_as_     = 1'b1;
    spm_rw      = WRITE;
    spm_addr    = '0;
    spm_wr_data = '0;
    owner_d     = OwnNone;
    if (gnt_tst) begin
      spm_as_     = 1'b0;
      spm_rw      = tst_rw;
      spm_addr    = tst_addr;
      spm_wr_data = tst_wr_data;
      if (tst_rw == READ) owner_d = OwnTst;
    end else if (gnt_mem) begin
      spm_as_     = 1'b0;
      spm_rw      = mem_rw;
      spm_addr    = mem_addr;
      spm_wr_data = mem_wr_data;
      if (mem_rw == READ) owner_d = OwnMem;
    end else if (gnt_if) begin
      spm_as_     = 1'b0;
      spm_rw      = READ;
      spm_addr    = if_addr;
      owner_d     = OwnIf;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (cpu_en && tst_as_) state_d = StRun;
      StRun:   if (!cpu_en) state_d = StDrain;
      StDrain: if (owner_q == OwnNone) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // Fetch loses only while it is actually waiting; any fetch idle or win clears the count.
  always_comb begin
    starve_d = starve_q;
    if (if_as_ || gnt_if)         starve_d = '0;
    else if (gnt_mem && !starved) starve_d = starve_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StLoad;
      owner_q  <= OwnNone;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign tst_rdy    = gnt_tst;
  assign mem_rdy    = gnt_mem;
  assign if_rdy     = gnt_if;
  assign tst_rd_vld = !reset && (owner_q == OwnTst);
  assign mem_rd_vld = !reset && (owner_q == OwnMem);
  assign if_rd_vld  = !reset && (owner_q == OwnIf);
  assign rd_data    = spm_rd_data;
  assign mode       = state_q;

endmodule

// File: tb/tb_spm_arbiter.sv
// Directed bench for spm_arbiter with a behavioural single-port SPM behind it.
module tb_spm_arbiter;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_en;
  logic              tst_as_, tst_rw, tst_rdy, tst_rd_vld;
  logic [ADDR_W-1:0] tst_addr;
  logic [DATA_W-1:0] tst_wr_data;
  logic              mem_as_, mem_rw, mem_rdy, mem_rd_vld;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              if_as_, if_rdy, if_rd_vld;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] rd_data;
  logic              spm_as_, spm_rw;
  logic [ADDR_W-1:0] spm_addr;
  logic [DATA_W-1:0] spm_wr_data;
  logic [DATA_W-1:0] spm_rd_data;
  logic [1:0]        mode;

  logic [DATA_W-1:0] spm [64];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en),
    .tst_as_(tst_as_), .tst_rw(tst_rw), .tst_addr(tst_addr), .tst_wr_data(tst_wr_data),
    .tst_rdy(tst_rdy), .tst_rd_vld(tst_rd_vld),
    .mem_as_(mem_as_), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rdy(mem_rdy), .mem_rd_vld(mem_rd_vld),
    .if_as_(if_as_), .if_addr(if_addr), .if_rdy(if_rdy), .if_rd_vld(if_rd_vld),
    .rd_data(rd_data), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_addr(spm_addr),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data), .mode(mode)
  );

  // SPM model: read data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (!spm_as_) begin
      if (spm_rw) spm_rd_data <= spm[spm_addr[5:0]];
      else        spm[spm_addr[5:0]] <= spm_wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    tst_as_ = 1'b1; tst_rw = 1'b1; tst_addr = '0; tst_wr_data = '0;
    mem_as_ = 1'b1; mem_rw = 1'b1; mem_addr = '0; mem_wr_data = '0;
    if_as_  = 1'b1; if_addr = '0;
  endtask

  task automatic tst_write(input int a, input logic [31:0] d);
    @(negedge clk);
    idle();
    tst_as_ = 1'b0; tst_rw = 1'b0; tst_addr = ADDR_W'(a); tst_wr_data = d;
    mem_as_ = 1'b0; if_as_ = 1'b0; // CPU ports request but must be blocked in LOAD
    #1;
    check("load_tst_rdy", 32'(tst_rdy), 32'd1);
    check("load_spm_rw", 32'(spm_rw), 32'd0);
    check("load_mem_rdy", 32'(mem_rdy), 32'd0);
    check("load_if_rdy", 32'(if_rdy), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_mem [6];
    logic [31:0] exp_if [6];
    bit seen;
    exp_mem[0] = 1; exp_mem[1] = 1; exp_mem[2] = 1; exp_mem[3] = 1; exp_mem[4] = 0; exp_mem[5] = 1;
    exp_if[0]  = 0; exp_if[1]  = 0; exp_if[2]  = 0; exp_if[3]  = 0; exp_if[4]  = 1; exp_if[5]  = 0;
    spm_rd_data = '0;
    for (int i = 0; i < 64; i++) spm[i] = '0;
    reset = 1'b1; cpu_en = 1'b0;
    idle();
    tst_as_ = 1'b0; tst_addr = ADDR_W'(5); tst_rw = 1'b0; tst_wr_data = 32'h55;
    #12;
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_spm_as", 32'(spm_as_), 32'd1);
    check("rst_tst_rdy", 32'(tst_rdy), 32'd0);
    check("rst_spm_addr", 32'(spm_addr), 32'd0);
    check("rst_spm_wr_data", spm_wr_data, 32'd0);
    check("rst_vld", 32'({tst_rd_vld, mem_rd_vld, if_rd_vld}), 32'd0);
    @(negedge clk); idle(); reset = 1'b0;

    // Loader fills program memory, then a few distinct words
    for (int a = 0; a <= 40; a++) tst_write(a, 32'h0000_0013);
    tst_write(8, 32'hDEAD_BEEF);
    tst_write(16, 32'h1111_1111);
    tst_write(20, 32'h2222_2222);
    @(negedge clk); idle();
    tst_as_ = 1'b0; tst_rw = 1'b1; tst_addr = ADDR_W'(16);
    #1 check("load_rd_rdy", 32'(tst_rdy), 32'd1);
    @(negedge clk); idle(); #1;
    check("load_rd_vld", 32'(tst_rd_vld), 32'd1);
    check("load_rd_data", rd_data, 32'h1111_1111);

    // cpu_en rises while tst busy: stay in LOAD until released
    @(negedge clk); tst_as_ = 1'b0; tst_rw = 1'b1; tst_addr = ADDR_W'(1); cpu_en = 1'b1;
    @(negedge clk); #1 check("hold_load_mode", 32'(mode), 32'd0);
    idle();
    @(negedge clk); #1 check("run_mode", 32'(mode), 32'd1);

    // Fetch
    if_as_ = 1'b0; if_addr = ADDR_W'(8); #1;
    check("fetch_rdy", 32'(if_rdy), 32'd1);
    check("fetch_spm_rw", 32'(spm_rw), 32'd1);
    check("fetch_spm_addr", 32'(spm_addr), 32'd8);
    @(negedge clk); idle(); #1;
    check("fetch_vld", 32'(if_rd_vld), 32'd1);
    check("fetch_data", rd_data, 32'hDEAD_BEEF);

    // Conflict: mem beats if, returns in order
    @(negedge clk);
    mem_as_ = 1'b0; mem_rw = 1'b1; mem_addr = ADDR_W'(16); if_as_ = 1'b0; if_addr = ADDR_W'(20);
    #1;
    check("conf_mem_rdy", 32'(mem_rdy), 32'd1);
    check("conf_if_rdy0", 32'(if_rdy), 32'd0);
    @(negedge clk); mem_as_ = 1'b1; #1;
    check("conf_if_rdy1", 32'(if_rdy), 32'd1);
    check("conf_mem_vld", 32'(mem_rd_vld), 32'd1);
    check("conf_if_vld0", 32'(if_rd_vld), 32'd0);
    check("conf_mem_data", rd_data, 32'h1111_1111);
    @(negedge clk); idle(); #1;
    check("conf_if_vld1", 32'(if_rd_vld), 32'd1);
    check("conf_mem_vld0", 32'(mem_rd_vld), 32'd0);
    check("conf_if_data", rd_data, 32'h2222_2222);

    // Starvation: mem wins four times, then fetch is forced through
    @(negedge clk);
    mem_as_ = 1'b0; mem_addr = ADDR_W'(16); if_as_ = 1'b0; if_addr = ADDR_W'(20);
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("starve_mem_rdy%0d", c), 32'(mem_rdy), exp_mem[c]);
      check($sformatf("starve_if_rdy%0d", c), 32'(if_rdy), exp_if[c]);
      @(negedge clk);
    end
    idle();

    // Mem write produces no vld; tst outranks mem in RUN
    @(negedge clk);
    mem_as_ = 1'b0; mem_rw = 1'b0; mem_addr = ADDR_W'(30); mem_wr_data = 32'hCAFE_F00D;
    #1;
    check("mw_rdy", 32'(mem_rdy), 32'd1);
    check("mw_spm_rw", 32'(spm_rw), 32'd0);
    check("mw_wr_data", spm_wr_data, 32'hCAFE_F00D);
    @(negedge clk);
    idle();
    tst_as_ = 1'b0; tst_rw = 1'b1; tst_addr = ADDR_W'(30); mem_as_ = 1'b0; mem_addr = ADDR_W'(16);
    #1;
    check("mw_no_vld", 32'(mem_rd_vld), 32'd0);
    check("prio_tst_rdy", 32'(tst_rdy), 32'd1);
    check("prio_mem_rdy", 32'(mem_rdy), 32'd0);
    @(negedge clk); idle(); #1;
    check("prio_tst_vld", 32'(tst_rd_vld), 32'd1);
    check("prio_tst_data", rd_data, 32'hCAFE_F00D);

    // Mode switch on the cycle of a granted fetch
    @(negedge clk);
    if_as_ = 1'b0; if_addr = ADDR_W'(8); cpu_en = 1'b0;
    #1 check("sw_if_rdy", 32'(if_rdy), 32'd1);
    @(negedge clk); idle(); mem_as_ = 1'b0; #1;
    check("sw_mode_drain", 32'(mode), 32'd2);
    check("sw_if_vld", 32'(if_rd_vld), 32'd1);
    check("sw_data", rd_data, 32'hDEAD_BEEF);
    check("sw_drain_mem_rdy", 32'(mem_rdy), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk); #1;
      if (mode == 2'd0) seen = 1'b1;
    end
    check("sw_reach_load", 32'(seen), 32'd1);
    idle(); tst_as_ = 1'b0; tst_rw = 1'b0; tst_addr = ADDR_W'(40); tst_wr_data = 32'h13; #1;
    check("sw_tst_rdy", 32'(tst_rdy), 32'd1);

    // Reset during an outstanding fetch drops its return
    @(negedge clk); idle(); cpu_en = 1'b1;
    @(negedge clk); #1 check("r_run_mode", 32'(mode), 32'd1);
    if_as_ = 1'b0; if_addr = ADDR_W'(8); #1;
    check("r_if_rdy", 32'(if_rdy), 32'd1);
    @(posedge clk); #2 reset = 1'b1; #1;
    check("r_if_vld", 32'(if_rd_vld), 32'd0);
    check("r_spm_as", 32'(spm_as_), 32'd1);
    check("r_if_rdy_off", 32'(if_rdy), 32'd0);
    check("r_mode", 32'(mode), 32'd0);
    @(negedge clk); idle(); cpu_en = 1'b0; reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("r_no_vld%0d", c), 32'({tst_rd_vld, mem_rd_vld, if_rd_vld}), 32'd0);
      check($sformatf("r_mode_load%0d", c), 32'(mode), 32'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
